// File: rtl/cam_lru_cache_pkg.sv
// Shared types and constants for the cam_lru_cache slice.
package cam_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } cam_state_t;

    localparam int STATS_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_lru_age.sv
// True-LRU age tracker: ages form a permutation of 0..WORDS-1, 0 = most recent.
// Two ordered touch ports per cycle; port 1 is applied after port 0.
module cam_lru_age #(
    parameter int WORDS = 8,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            touch_en,
    input  logic [1:0][IDX_W-1:0] touch_idx,
    input  logic                  age_clr,
    output logic [IDX_W-1:0]      lru_idx
);

    logic [WORDS-1:0][IDX_W-1:0] age_q, age_d, age_mid;

    function automatic logic [WORDS-1:0][IDX_W-1:0] touch_ages(
        input logic [WORDS-1:0][IDX_W-1:0] ages,
        input logic [IDX_W-1:0]            idx
    );
        logic [WORDS-1:0][IDX_W-1:0] res;
        logic [IDX_W-1:0]            old;
        old = ages[idx];
        for (int i = 0; i < WORDS; i++) begin
            if (IDX_W'(i) == idx) begin
                res[i] = '0;
            end else if (ages[i] < old) begin
                res[i] = ages[i] + IDX_W'(1);
            end else begin
                res[i] = ages[i];
            end
        end
        return res;
    endfunction

    // Apply the ordered touches, or restore the identity order after a flush.
    always_comb begin
        age_mid = touch_en[0] ? touch_ages(age_q, touch_idx[0]) : age_q;
        age_d   = touch_en[1] ? touch_ages(age_mid, touch_idx[1]) : age_mid;
        if (age_clr) begin
            for (int i = 0; i < WORDS; i++) begin
                age_d[i] = IDX_W'(i);
            end
        end else begin
            age_d = age_d;
        end
    end

    // Locate the entry holding the oldest age.
    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < WORDS; i++) begin
            lru_idx = lru_idx | ((age_q[i] == IDX_W'(WORDS - 1)) ? IDX_W'(i) : '0);
        end
    end

    // Age array register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cam_lru_cache.sv
// Fully associative tag/data CAM with registered lookup, LRU fill and flush engine.
// Define CAM_STATS_EN to add saturating hit_cnt/miss_cnt lookup counters.
module cam_lru_cache
    import cam_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int BITS   = 8,
    parameter int TAG_SZ = 8,
    parameter int IDX_W  = idx_w(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid,
    output logic              lookup_rdy,
    input  logic [TAG_SZ-1:0] lookup_tag,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [BITS-1:0]   rsp_data,
    output logic [IDX_W-1:0]  rsp_index,
    input  logic              fill_valid,
    output logic              fill_rdy,
    input  logic [TAG_SZ-1:0] fill_tag,
    input  logic [BITS-1:0]   fill_data,
    input  logic              inval_valid,
    input  logic [TAG_SZ-1:0] inval_tag,
    input  logic              flush,
`ifdef CAM_STATS_EN
    output logic              busy,
    output logic [STATS_W-1:0] hit_cnt,
    output logic [STATS_W-1:0] miss_cnt
`else
    output logic              busy
`endif
);

    cam_state_t                   state_q;
    logic [IDX_W-1:0]             cnt_q;
    logic                         busy_q;
    logic [WORDS-1:0]             val_q, val_d;
    logic [WORDS-1:0][TAG_SZ-1:0] tag_q, tag_d;
    logic [WORDS-1:0][BITS-1:0]   data_q, data_d;
    logic                         rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
    logic [BITS-1:0]              rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0]             rsp_index_q, rsp_index_d;

    logic             lk_acc, fill_acc, inval_acc, flush_start, flush_done;
    logic             lk_hit, fl_hit, has_free;
    logic [IDX_W-1:0] lk_idx, fl_idx, free_idx, fill_idx, lru_idx;
    logic [BITS-1:0]  lk_data;

    assign lookup_rdy  = !busy_q;
    assign fill_rdy    = !busy_q && !inval_valid;
    assign lk_acc      = lookup_valid && lookup_rdy;
    assign fill_acc    = fill_valid && fill_rdy;
    assign inval_acc   = inval_valid && !busy_q;
    assign flush_start = (state_q == IDLE) && flush;
    assign flush_done  = (state_q == FLUSH) && (cnt_q == IDX_W'(WORDS - 1));

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_index = rsp_index_q;

    // Tag searches; tags are unique so OR-reduction of the matching entry is exact.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        lk_data  = '0;
        fl_hit   = 1'b0;
        fl_idx   = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < WORDS; i++) begin
            lk_hit  = lk_hit | (val_q[i] && (tag_q[i] == lookup_tag));
            lk_idx  = lk_idx | ((val_q[i] && (tag_q[i] == lookup_tag)) ? IDX_W'(i) : '0);
            lk_data = lk_data | ((val_q[i] && (tag_q[i] == lookup_tag)) ? data_q[i] : '0);
            fl_hit  = fl_hit | (val_q[i] && (tag_q[i] == fill_tag));
            fl_idx  = fl_idx | ((val_q[i] && (tag_q[i] == fill_tag)) ? IDX_W'(i) : '0);
        end
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!val_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                has_free = has_free;
            end
        end
    end

    assign fill_idx = fl_hit ? fl_idx : (has_free ? free_idx : lru_idx);

    // Next-state for the entry array and the lookup response.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (fill_acc) begin
            val_d[fill_idx]  = 1'b1;
            tag_d[fill_idx]  = fill_tag;
            data_d[fill_idx] = fill_data;
        end else if (inval_acc) begin
            for (int i = 0; i < WORDS; i++) begin
                val_d[i] = val_q[i] && (tag_q[i] != inval_tag);
            end
        end else if (state_q == FLUSH) begin
            val_d[cnt_q] = 1'b0;
        end else begin
            val_d = val_q;
        end
        rsp_valid_d = lk_acc;
        rsp_hit_d   = lk_acc && lk_hit;
        rsp_data_d  = (lk_acc && lk_hit) ? lk_data : '0;
        rsp_index_d = (lk_acc && lk_hit) ? lk_idx : '0;
    end

    cam_lru_age #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_age (
        .clk       (clk),
        .rst       (rst),
        .touch_en  ({fill_acc, lk_acc && lk_hit}),
        .touch_idx ({fill_idx, lk_idx}),
        .age_clr   (flush_done),
        .lru_idx   (lru_idx)
    );

    // Flush sequencer: walks every entry once, one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_q == IDX_W'(WORDS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Entry array and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q       <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_index_q <= '0;
        end else begin
            val_q       <= val_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
            rsp_index_q <= rsp_index_d;
        end
    end

`ifdef CAM_STATS_EN
    logic [STATS_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Saturating lookup counters; a flush start wins over a same-cycle lookup.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_start) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (lk_acc && lk_hit) begin
            hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + STATS_W'(1);
        end else if (lk_acc) begin
            miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + STATS_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cam_lru_cache.sv
// Directed self-checking bench for cam_lru_cache (WORDS=4); covers CAM_STATS_EN when defined.
module tb_cam_lru_cache;

    logic       clk = 1'b0;
    logic       rst;
    logic       lookup_valid, lookup_rdy;
    logic [7:0] lookup_tag;
    logic       rsp_valid, rsp_hit;
    logic [7:0] rsp_data;
    logic [1:0] rsp_index;
    logic       fill_valid, fill_rdy;
    logic [7:0] fill_tag, fill_data;
    logic       inval_valid;
    logic [7:0] inval_tag;
    logic       flush, busy;
`ifdef CAM_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cam_lru_cache #(
        .WORDS  (4),
        .BITS   (8),
        .TAG_SZ (8),
        .IDX_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_rdy   (lookup_rdy),
        .lookup_tag   (lookup_tag),
        .rsp_valid    (rsp_valid),
        .rsp_hit      (rsp_hit),
        .rsp_data     (rsp_data),
        .rsp_index    (rsp_index),
        .fill_valid   (fill_valid),
        .fill_rdy     (fill_rdy),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .inval_valid  (inval_valid),
        .inval_tag    (inval_tag),
        .flush        (flush),
`ifdef CAM_STATS_EN
        .busy         (busy),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`else
        .busy         (busy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [7:0] t, input logic [7:0] d);
        fill_valid = 1'b1; fill_tag = t; fill_data = d;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic do_lookup(input string tag, input logic [7:0] t,
                             input logic hit, input logic [7:0] d, input logic [1:0] idx);
        lookup_valid = 1'b1; lookup_tag = t;
        tick();
        lookup_valid = 1'b0;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(1'b1));
        chk({tag, ".hit"},   32'(rsp_hit),   32'(hit));
        chk({tag, ".data"},  32'(rsp_data),  32'(d));
        chk({tag, ".index"}, 32'(rsp_index), 32'(idx));
    endtask

    initial begin
        rst = 1'b1;
        lookup_valid = 1'b0; lookup_tag = 8'h00;
        fill_valid = 1'b0; fill_tag = 8'h00; fill_data = 8'h00;
        inval_valid = 1'b0; inval_tag = 8'h00; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_hit",   32'(rsp_hit),   32'd0);
        chk("reset.rsp_data",  32'(rsp_data),  32'd0);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.lookup_rdy", 32'(lookup_rdy), 32'd1);
        tick();

        do_fill(8'h10, 8'hA1);
        do_fill(8'h20, 8'hA2);
        do_fill(8'h30, 8'hA3);
        do_fill(8'h40, 8'hA4);
        do_lookup("hit30", 8'h30, 1'b1, 8'hA3, 2'd2);
        tick();
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // LRU victim: after touching 0x30 and 0x10, 0x20 at index 1 is oldest.
        do_lookup("hit10", 8'h10, 1'b1, 8'hA1, 2'd0);
        do_fill(8'h50, 8'hB5);
        do_lookup("miss20", 8'h20, 1'b0, 8'h00, 2'd0);
        do_lookup("hit50",  8'h50, 1'b1, 8'hB5, 2'd1);

        do_fill(8'h30, 8'hC3);
        do_lookup("upd30", 8'h30, 1'b1, 8'hC3, 2'd2);

        inval_valid = 1'b1; inval_tag = 8'h40;
        fill_valid = 1'b1; fill_tag = 8'h60; fill_data = 8'hD6;
        #1;
        chk("inval_blocks_fill", 32'(fill_rdy), 32'd0);
        tick();
        inval_valid = 1'b0; fill_valid = 1'b0;
        do_lookup("miss40", 8'h40, 1'b0, 8'h00, 2'd0);
        do_fill(8'h60, 8'hD6);
        do_lookup("hit60", 8'h60, 1'b1, 8'hD6, 2'd3);

        // Lookup in the flush-start cycle still sees pre-flush contents.
        flush = 1'b1; lookup_valid = 1'b1; lookup_tag = 8'h50;
        tick();
        flush = 1'b0; lookup_valid = 1'b0;
        chk("flushcyc.hit",  32'(rsp_hit),  32'd1);
        chk("flushcyc.data", 32'(rsp_data), 32'hB5);
        chk("flush.lookup_rdy", 32'(lookup_rdy), 32'd0);
        lookup_valid = 1'b1; lookup_tag = 8'h10;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("flush.busy%0d", k), 32'(busy), 32'd1);
            tick();
            chk($sformatf("flush.no_rsp%0d", k), 32'(rsp_valid), 32'd0);
        end
        lookup_valid = 1'b0;
        chk("flush.done", 32'(busy), 32'd0);
        do_lookup("postflush10", 8'h10, 1'b0, 8'h00, 2'd0);
        do_lookup("postflush30", 8'h30, 1'b0, 8'h00, 2'd0);
        do_lookup("postflush60", 8'h60, 1'b0, 8'h00, 2'd0);

        // Reset during the second flush cycle aborts immediately.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("midflush.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midflush.rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

`ifdef CAM_STATS_EN
        do_fill(8'h11, 8'h77);
        do_lookup("st.h1", 8'h11, 1'b1, 8'h77, 2'd0);
        do_lookup("st.m1", 8'h99, 1'b0, 8'h00, 2'd0);
        do_lookup("st.h2", 8'h11, 1'b1, 8'h77, 2'd0);
        do_lookup("st.m2", 8'h98, 1'b0, 8'h00, 2'd0);
        do_lookup("st.h3", 8'h11, 1'b1, 8'h77, 2'd0);
        chk("stats.hit",  hit_cnt,  32'd3);
        chk("stats.miss", miss_cnt, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stats.hit_clr",  hit_cnt,  32'd0);
        chk("stats.miss_clr", miss_cnt, 32'd0);
        for (int k = 0; k < 5; k++) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_lru_cache.md
Name: cam_lru_cache

Overview:
- Parametrised, fully associative tag/data CAM cache; successor to the single-port 8-entry CAM.
- Adds registered lookup with a response handshake, automatic victim selection (first invalid entry, else true-LRU), in-place update on tag re-fill, invalidate-by-tag, and a multi-cycle flush engine.
- Sits between the request pipeline and backing memory; the miss handler supplies fills.

Parameters:
- WORDS, 8, number of entries (power of 2, >= 2)
- BITS, 8, data width per entry
- TAG_SZ, 8, tag width
- IDX_W, $clog2(WORDS), entry index and age-counter width

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- lookup_valid  input  1  lookup request
- lookup_rdy  output  1  lookup accepted (= !busy)
- lookup_tag  input  TAG_SZ  tag to search
- rsp_valid  output  1  lookup response valid
- rsp_hit  output  1  tag found
- rsp_data  output  BITS  hit data, 0 on miss
- rsp_index  output  IDX_W  hit entry, 0 on miss
- fill_valid  input  1  fill request
- fill_rdy  output  1  fill accepted (= !busy && !inval_valid)
- fill_tag  input  TAG_SZ  tag to install
- fill_data  input  BITS  data to install
- inval_valid  input  1  invalidate request (always accepted when !busy)
- inval_tag  input  TAG_SZ  tag to invalidate
- flush  input  1  start-flush pulse
- busy  output  1  flush in progress

Behaviour:
- Reset: all val bits 0, data/tag 0, ages = entry index. Outputs rsp_valid=0, rsp_hit=0, rsp_data=0, rsp_index=0, busy=0. Reset mid-flush aborts to IDLE.
- Lookup: accepted when lookup_valid && lookup_rdy. Response registered, 1-cycle latency: rsp_valid is high in the cycle after acceptance for exactly one cycle. The search uses contents before any same-cycle write. Tags are unique, so at most one entry matches.
- Hit: age of the matching entry becomes 0; every entry with age < old age increments. Ages remain a permutation of 0..WORDS-1.
- Fill: accepted when fill_valid && fill_rdy.
  - If fill_tag matches a valid entry, that entry's data is updated and it is touched.
  - Otherwise the victim is the lowest-index invalid entry, else the entry with age WORDS-1. The victim is written with val=1 and touched.
  - When a lookup hit and a fill occur in the same cycle, the fill touch is applied after the hit touch (fill becomes MRU).
- Invalidate: clears the val bit of the matching valid entry; ages are unchanged. No match means no effect. Priority over fill in the same cycle (fill_rdy=0).
- FSM, 2 states:
  - IDLE: flush=1 moves to FLUSH with counter=0 and busy=1.
  - FLUSH: clears val[counter] each cycle. After counter=WORDS-1 returns to IDLE and resets ages to entry index. Takes exactly WORDS cycles.
  - flush asserted during FLUSH is ignored.
  - While busy, lookup, fill and invalidate are not accepted. A lookup accepted in the cycle flush is asserted still completes against pre-flush contents.

Optional Feature:
- CAM_STATS_EN defined: adds outputs hit_cnt and miss_cnt (32 bits each).
  - Each counts accepted lookups; both saturate at all-ones.
  - Both clear on rst and at flush start.
- Undefined: the ports and counters are absent.

Decomposition:
- cam_pkg holds:
  - cam_state_t enum {IDLE, FLUSH}
  - stats counter width constant
  - index-width helper
- One sub-module, cam_lru_age: holds the age array and performs the touch/victim computation (inputs touch_en, touch_idx; output lru_idx). Instantiated once.

Test Plan (WORDS=4, BITS=8, TAG_SZ=8):
- Fill tags 0x10,0x20,0x30,0x40 with data 0xA1..0xA4, then lookup 0x30 -> rsp_valid next cycle, rsp_hit=1, rsp_data=0xA3, rsp_index=2.
- After the above, lookup 0x10, then fill 0x50/0xB5 -> victim is index 1 (tag 0x20, LRU); lookup 0x20 -> miss, data 0; lookup 0x50 -> hit, index 1.
- Fill 0x30 with 0xC3 while 0x30 is present -> index 2 updated in place, no duplicate; lookup 0x30 -> 0xC3.
- inval 0x40 and fill 0x60 in the same cycle -> fill_rdy=0; 0x40 invalidated; next-cycle fill 0x60 lands in index 3 (lowest invalid).
- Pulse flush -> busy=1 for exactly 4 cycles, lookup_rdy=0; afterwards all lookups miss. Assert rst on cycle 2 of a flush -> busy=0 immediately.
- With CAM_STATS_EN defined: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2; flush -> both 0.
